load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the single-cycle core's EX/MEM datapath and the byte-array data memory.
//  Converts MIPS lb/lbu/lh/lhu/lw/sb/sh/sw requests into word-aligned memory accesses.
//  Loads are extracted and sign/zero-extended. Sub-word stores use read-modify-write,
//  because the memory always writes all 4 bytes.
//  Misaligned and out-of-range accesses are flagged and never reach memory.
// PARAMETERS
//  MEM_BYTES  1024  data memory size in bytes; addr_i >= MEM_BYTES is out of range
// PORTS
//  clk_i        in   1   clock, rising edge
//  rst_i        in   1   reset, asynchronous, active-low
//  req_i        in   1   request strobe; sampled only while busy_o=0
//  we_i         in   1   1=store, 0=load
//  size_i       in   2   00=byte, 01=half, 10=word; 11 is treated as misaligned
//  sign_i       in   1   loads: 1=sign-extend, 0=zero-extend; ignored for stores
//  addr_i       in   32  byte address
//  wdata_i      in   32  store data; byte/half taken from the low bits
//  busy_o       out  1   1 in every state except IDLE
//  done_o       out  1   one-cycle completion pulse
//  rdata_o      out  32  load result; valid while done_o=1, held until next load done
//  misalign_o   out  1   qualifies done_o: alignment fault
//  range_err_o  out  1   qualifies done_o: address >= MEM_BYTES
//  mem_addr_o   out  32  {addr[31:2],2'b00} of the latched request
//  mem_wdata_o  out  32  full word to memory
//  mem_read_o   out  1   memory read enable; memory returns data combinationally
//  mem_write_o  out  1   memory write enable; memory commits on the rising edge
//  mem_rdata_i  in   32  memory read word, little-endian (addr[1:0]=0 -> bits 7:0)
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0, including rdata_o and the internal address/data latches.
//  Accept: in IDLE with req_i=1, latch we/size/sign/addr/wdata.
//   Fault check (priority: misalign, then range):
//   - size=01 with addr[0]!=0 -> misaligned.
//   - size=10 with addr[1:0]!=0 -> misaligned.
//   - size=11 -> misaligned.
//   - addr >= MEM_BYTES -> range error.
//   - Any fault -> next state FAULT; otherwise see state rules below.
//  States:
//   IDLE -> RD for a load or a sub-word store; IDLE -> WR for a word store.
//   RD: mem_read_o=1, mem_addr_o=aligned addr; capture mem_rdata_i at the clock edge.
//       Load -> DONE. Sub-word store -> WR.
//   WR: mem_write_o=1, mem_addr_o=aligned addr.
//       Word store: mem_wdata_o=wdata.
//       Sub-word store: mem_wdata_o=captured word with the selected lane(s) replaced by
//       wdata[7:0] (byte lane addr[1:0]) or wdata[15:0] (half lane addr[1]). -> DONE.
//   DONE: done_o=1; misalign_o=range_err_o=0. -> IDLE.
//   FAULT: done_o=1 with misalign_o or range_err_o=1; no memory enables. -> IDLE.
//  Latency from the accept edge to the done_o cycle:
//   lw/lb/lh 2 cycles; sw 2; sb/sh 3; fault 1.
//  Load extract: byte = word[8*a+7:8*a], half = word[16*h+15:16*h];
//   extended per sign_i; rdata_o is updated on entry to DONE.
//  mem_read_o and mem_write_o are never both 1. Both are 0 in IDLE, DONE and FAULT.
//   mem_addr_o and mem_wdata_o are 0 when not enabled.
//  req_i while busy_o=1 is ignored, not queued. The core must stall on busy_o.
//   A new request is accepted in the cycle after DONE/FAULT (IDLE).
//  Reset mid-operation: asynchronously returns to IDLE and drops mem_* enables at once.
//   A write committed at an earlier edge remains in memory.
//   Reset in RD of an RMW store leaves memory unchanged.
// TESTING
//  1 mem[0x10]=0x80FF7F01; lb 0x13 -> rdata 0xFFFFFF80, done 2 cycles after accept;
//    lbu 0x13 -> 0x00000080.
//  2 mem[0x10]=0x80FF7F01; lh 0x12 -> 0xFFFF80FF; lhu 0x10 -> 0x00007F01;
//    lw 0x10 -> 0x80FF7F01.
//  3 mem[0x20]=0x11223344; sh 0xBEEF @0x22 -> mem 0xBEEF3344; sb 0xAA @0x21 -> 0xBEEFAA44;
//    busy_o 3 cycles each, one RD then one WR.
//  4 sw @0x06 -> misalign_o=1 with done_o after 1 cycle, mem_write_o never 1;
//    lw @0x400 -> range_err_o=1.
//  5 Reset asserted in RD of sb @0x31 -> busy_o=0 immediately; mem[0x30] unchanged;
//    next lw 0x30 completes normally.
//  6 Back-to-back sw 0xDEADBEEF @0x40 then lw 0x40 issued the cycle after done
//    -> rdata 0xDEADBEEF; req_i pulses while busy are ignored.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bus bundle for the load/store unit: the core request/response handshake
// plus the word-wide data memory port. The LSU takes the slave view; the
// core/memory side (or a testbench) takes the master view.
interface load_store_unit_if;
  // core request
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  // core response
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;
  logic        range_err;
  // data memory port
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  modport slave (
    input  req, we, size, sign, addr, wdata, mem_rdata,
    output busy, done, rdata, misalign, range_err,
           mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output req, we, size, sign, addr, wdata, mem_rdata,
    input  busy, done, rdata, misalign, range_err,
           mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit between the core's EX/MEM stage and a word-wide data memory.
// Sub-word loads are extracted and extended; sub-word stores are done as a
// read-modify-write because the memory always writes a full word. Misaligned
// and out-of-range requests are reported and never touch memory.
module load_store_unit #(
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  load_store_unit_if.slave  bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD    = 3'd1;
  localparam logic [2:0] ST_WR    = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  logic [2:0]  state_reg, state_next;
  logic        we_reg;
  logic [1:0]  size_reg;
  logic        sign_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] word_reg;
  logic [31:0] rdata_reg;
  logic        misalign_reg;
  logic        range_err_reg;

  logic        req_misalign;
  logic        req_range;
  logic        accept;
  logic [31:0] rd_shifted;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_ext;
  logic [3:0]  lane_hit;
  logic [7:0]  lane_new [4];
  logic [31:0] merged_word;
  logic [31:0] store_word;
  logic        mem_active;

  assign accept = (state_reg == ST_IDLE) && bus.req;

  // Alignment fault takes priority over the range check.
  assign req_misalign = ((bus.size == SZ_HALF) && bus.addr[0])
                     || ((bus.size == SZ_WORD) && (bus.addr[1:0] != 2'b00))
                     || (bus.size == 2'b11);
  assign req_range    = (bus.addr >= MEM_LIMIT);

  // Load extraction works straight off the memory bus during RD.
  assign rd_shifted = bus.mem_rdata >> {addr_reg[1:0], 3'b000};
  assign byte_val   = rd_shifted[7:0];
  assign half_val   = addr_reg[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

  // Select and sign/zero-extend the loaded field.
  always_comb begin
    load_ext = bus.mem_rdata;
    case (size_reg)
      SZ_BYTE: load_ext = {{24{sign_reg & byte_val[7]}}, byte_val};
      SZ_HALF: load_ext = {{16{sign_reg & half_val[15]}}, half_val};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  // Per-lane merge of store data into the word captured during RD.
  // Bytes take wdata[7:0] in one lane; halves take wdata[15:0] across two lanes.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_hit[gi] = (size_reg == SZ_BYTE) ? (addr_reg[1:0] == 2'(gi))
                                                  : (addr_reg[1] == 1'(gi / 2));
      assign lane_new[gi] = (size_reg == SZ_BYTE) ? wdata_reg[7:0]
                                                  : wdata_reg[8*(gi%2) +: 8];
      assign merged_word[8*gi +: 8] = lane_hit[gi] ? lane_new[gi]
                                                   : word_reg[8*gi +: 8];
    end
  endgenerate

  assign store_word = (size_reg == SZ_WORD) ? wdata_reg : merged_word;

  // Next-state selection for the request sequencer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.req) begin
          if (req_misalign || req_range)
            state_next = ST_FAULT;
          else if (bus.we && (bus.size == SZ_WORD))
            state_next = ST_WR;
          else
            state_next = ST_RD;
        end
      end
      ST_RD:    state_next = we_reg ? ST_WR : ST_DONE;
      ST_WR:    state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      ST_FAULT: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State, request latches, captured read word and load result.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg     <= ST_IDLE;
      we_reg        <= 1'b0;
      size_reg      <= 2'b00;
      sign_reg      <= 1'b0;
      addr_reg      <= 32'd0;
      wdata_reg     <= 32'd0;
      word_reg      <= 32'd0;
      rdata_reg     <= 32'd0;
      misalign_reg  <= 1'b0;
      range_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        we_reg        <= bus.we;
        size_reg      <= bus.size;
        sign_reg      <= bus.sign;
        addr_reg      <= bus.addr;
        wdata_reg     <= bus.wdata;
        misalign_reg  <= req_misalign;
        range_err_reg <= !req_misalign && req_range;
      end
      if (state_reg == ST_RD) begin
        word_reg <= bus.mem_rdata;
        if (!we_reg)
          rdata_reg <= load_ext;
      end
    end
  end

  assign mem_active    = (state_reg == ST_RD) || (state_reg == ST_WR);

  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.done      = (state_reg == ST_DONE) || (state_reg == ST_FAULT);
  assign bus.misalign  = (state_reg == ST_FAULT) && misalign_reg;
  assign bus.range_err = (state_reg == ST_FAULT) && range_err_reg;
  assign bus.rdata     = rdata_reg;
  assign bus.mem_read  = (state_reg == ST_RD);
  assign bus.mem_write = (state_reg == ST_WR);
  assign bus.mem_addr  = mem_active ? {addr_reg[31:2], 2'b00} : 32'd0;
  assign bus.mem_wdata = (state_reg == ST_WR) ? store_word : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array memory model and a
// scoreboard of expected completions.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_BYTES(1024)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  // Byte-addressed memory model, little-endian, full-word writes.
  logic [7:0]  mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;

  assign bus.mem_rdata = {mem[{bus.mem_addr[9:2], 2'd3}], mem[{bus.mem_addr[9:2], 2'd2}],
                          mem[{bus.mem_addr[9:2], 2'd1}], mem[{bus.mem_addr[9:2], 2'd0}]};

  always @(posedge clk) begin
    if (bus.mem_write) begin
      mem[{bus.mem_addr[9:2], 2'd0}] <= bus.mem_wdata[7:0];
      mem[{bus.mem_addr[9:2], 2'd1}] <= bus.mem_wdata[15:8];
      mem[{bus.mem_addr[9:2], 2'd2}] <= bus.mem_wdata[23:16];
      mem[{bus.mem_addr[9:2], 2'd3}] <= bus.mem_wdata[31:24];
    end else if (pre_we) begin
      mem[{pre_addr[9:2], 2'd0}] <= pre_data[7:0];
      mem[{pre_addr[9:2], 2'd1}] <= pre_data[15:8];
      mem[{pre_addr[9:2], 2'd2}] <= pre_data[23:16];
      mem[{pre_addr[9:2], 2'd3}] <= pre_data[31:24];
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        rng;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] model_rdata = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic mem_wr(input logic [9:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // Issue one request at the current negedge, follow it to done_o, score it,
  // and return at the negedge of the following idle cycle.
  task automatic issue(input string tag, input logic we, input logic [1:0] size,
                       input logic sign, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_load, input logic mis, input logic rng,
                       input int lat_exp, input int rd_exp, input int wr_exp,
                       input logic noise);
    exp_t e;
    int   lat = 0;
    int   busy_n = 0;
    int   rd_n = 0;
    int   wr_n = 0;
    bit   got = 1'b0;
    if (!we && !mis && !rng)
      model_rdata = exp_load;
    e.rdata = model_rdata;
    e.mis   = mis;
    e.rng   = rng;
    sbq.push_back(e);

    bus.req   = 1'b1;
    bus.we    = we;
    bus.size  = size;
    bus.sign  = sign;
    bus.addr  = addr;
    bus.wdata = wdata;
    @(posedge clk);
    #1 bus.req = 1'b0;

    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_n++;
      if (bus.mem_read) rd_n++;
      if (bus.mem_write) wr_n++;
      check({tag, "_excl"}, 32'(bus.mem_read & bus.mem_write), 32'd0);
      if (bus.mem_read || bus.mem_write) begin
        check({tag, "_maddr"}, bus.mem_addr, {addr[31:2], 2'b00});
      end else begin
        check({tag, "_maddr_off"}, bus.mem_addr, 32'd0);
        check({tag, "_mwdata_off"}, bus.mem_wdata, 32'd0);
      end
      if (bus.done) got = 1'b1;
      // Requests raised while busy must be ignored.
      bus.req = noise && !bus.done;
      if (bus.req) begin
        bus.we    = 1'b1;
        bus.size  = 2'b10;
        bus.addr  = 32'h40;
        bus.wdata = 32'h0;
      end
    end
    bus.req = 1'b0;

    check({tag, "_done_seen"}, 32'(got), 32'd1);
    e = sbq.pop_front();
    if (got) begin
      check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'(lat_exp));
      check({tag, "_rd_cycles"}, 32'(rd_n), 32'(rd_exp));
      check({tag, "_wr_cycles"}, 32'(wr_n), 32'(wr_exp));
      check({tag, "_rdata"}, bus.rdata, e.rdata);
      check({tag, "_misalign"}, 32'(bus.misalign), 32'(e.mis));
      check({tag, "_range"}, 32'(bus.range_err), 32'(e.rng));
    end
    $display("txn %s we=%0d size=%0d addr=%h lat=%0d rdata=%h mis=%0d rng=%0d",
             tag, we, size, addr, lat, bus.rdata, bus.misalign, bus.range_err);
    @(negedge clk);
    check({tag, "_idle_after"}, {30'd0, bus.busy, bus.done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.size  = 2'b00;
    bus.sign  = 1'b0;
    bus.addr  = 32'd0;
    bus.wdata = 32'd0;
    pre_we    = 1'b0;
    pre_addr  = 10'd0;
    pre_data  = 32'd0;

    // Reset state
    #2;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_mem_read", 32'(bus.mem_read), 32'd0);
    check("rst_mem_write", 32'(bus.mem_write), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_flags", {30'd0, bus.misalign, bus.range_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Byte and half loads with sign/zero extension, word load
    mem_wr(10'h10, 32'h80FF7F01);
    issue("lb_13",  1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0, 2, 1, 0, 1'b0);
    issue("lbu_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h00000080, 1'b0, 1'b0, 2, 1, 0, 1'b0);
    issue("lb_11",  1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h0000007F, 1'b0, 1'b0, 2, 1, 0, 1'b0);
    issue("lh_12",  1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF80FF, 1'b0, 1'b0, 2, 1, 0, 1'b0);
    issue("lhu_10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h00007F01, 1'b0, 1'b0, 2, 1, 0, 1'b0);
    issue("lw_10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80FF7F01, 1'b0, 1'b0, 2, 1, 0, 1'b0);

    // Sub-word read-modify-write stores
    mem_wr(10'h20, 32'h11223344);
    issue("sh_22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h1234BEEF, 32'h0, 1'b0, 1'b0, 3, 1, 1, 1'b0);
    check("sh_22_mem", mem_word(32'h20), 32'hBEEF3344);
    issue("sb_21", 1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFFAA, 32'h0, 1'b0, 1'b0, 3, 1, 1, 1'b0);
    check("sb_21_mem", mem_word(32'h20), 32'hBEEFAA44);

    // Faults: misalignment beats range, boundary addresses
    issue("sw_06_mis",   1'b1, 2'b10, 1'b0, 32'h06, 32'h12345678, 32'h0, 1'b1, 1'b0, 1, 0, 0, 1'b0);
    check("sw_06_mem", mem_word(32'h04) === 32'h12345678 ? 32'd1 : 32'd0, 32'd0);
    issue("lw_400_rng",  1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, 1'b0, 1'b1, 1, 0, 0, 1'b0);
    issue("size11_mis",  1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0, 0, 1'b0);
    issue("lh_401_mis",  1'b0, 2'b01, 1'b1, 32'h401, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0, 0, 1'b0);
    issue("lw_high_rng", 1'b0, 2'b10, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h0, 1'b0, 1'b1, 1, 0, 0, 1'b0);
    mem_wr(10'h3FC, 32'h0BADF00D);
    issue("lw_3fc",      1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 32'h0BADF00D, 1'b0, 1'b0, 2, 1, 0, 1'b0);

    // Reset during the read phase of a byte store
    mem_wr(10'h30, 32'hCAFEF00D);
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.size  = 2'b00;
    bus.sign  = 1'b0;
    bus.addr  = 32'h31;
    bus.wdata = 32'h55;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    check("sb_31_in_rd", 32'(bus.mem_read), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_enables", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    check("rst_mid_addr", bus.mem_addr, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_rdata = 32'd0;
    check("rst_mid_mem", mem_word(32'h30), 32'hCAFEF00D);
    check("rst_mid_rdata", bus.rdata, 32'd0);
    issue("lw_30", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, 2, 1, 0, 1'b0);

    // Back-to-back store then load, with stray requests while busy
    issue("sw_40", 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 2, 0, 1, 1'b1);
    check("sw_40_mem", mem_word(32'h40), 32'hDEADBEEF);
    issue("lw_40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 2, 1, 0, 1'b1);
    check("lw_40_mem", mem_word(32'h40), 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
